// File: rtl/stroke_pkg.sv
// Shared types for the stroke sequencer: point layout and FSM states.
// A point packs {pen, x, y} with pen in the MSB and y in the LSBs.
package stroke_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int PT_W    = 1 + X_W + Y_W;
    localparam int Y_LSB   = 0;
    localparam int X_LSB   = Y_W;
    localparam int PEN_BIT = X_W + Y_W;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic           pen;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    function automatic point_t pack_pt(
        input logic           pen,
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        point_t p;
        p.pen = pen;
        p.x   = x;
        p.y   = y;
        return p;
    endfunction

endpackage

// File: rtl/stroke_point_fifo.sv
// Synchronous point FIFO with a combinational head read.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module stroke_point_fifo
    import stroke_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Advance pointers; a full FIFO refuses pushes even on a pop cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stroke_sequencer.sv
// Turns a queue of sampled mouse points into line segments for the
// line drawer, one start/done handshake at a time.
module stroke_sequencer
    import stroke_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pt_valid,
    input  logic           pt_pen,
    input  logic [X_W-1:0] pt_x,
    input  logic [Y_W-1:0] pt_y,
    output logic           pt_ready,
    output logic           ld_start,
    output logic [X_W-1:0] ld_x0,
    output logic [Y_W-1:0] ld_y0,
    output logic [X_W-1:0] ld_x1,
    output logic [Y_W-1:0] ld_y1,
    input  logic           ld_done,
    output logic           busy,
    output logic [7:0]     drop_cnt,
    output logic           timeout_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_d;
    point_t          in_pt;
    point_t          head;
    point_t          anc;
    logic            anc_valid;
    logic [PT_W-1:0] head_raw;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            issue;
    logic            dot;
    logic            expire;
    logic [CW-1:0]   cnt;

    assign in_pt    = pack_pt(pt_pen, pt_x, pt_y);
    assign head     = point_t'(head_raw);
    assign push     = pt_valid && !full;
    assign pt_ready = !full;
    assign busy     = (state != IDLE) || !empty;

    stroke_point_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_pt),
        .dout  (head_raw),
        .full  (full),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Pop/issue decision in IDLE, done/timeout exit in WAIT.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        issue   = 1'b0;
        dot     = 1'b0;
        expire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.pen) begin
                        if (!(anc_valid && anc.pen)) begin
                            issue = 1'b1;
                            dot   = 1'b1;
                        end else if (head.x != anc.x ||
                                     head.y != anc.y) begin
                            issue = 1'b1;
                        end
                    end
                    if (issue)
                        state_d = WAIT;
                end
            end
            WAIT: begin
                if (ld_done) begin
                    state_d = IDLE;
                end else if (cnt == LAST) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Anchor, segment endpoints, wait counter and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anc         <= '0;
            anc_valid   <= 1'b0;
            ld_start    <= 1'b0;
            ld_x0       <= '0;
            ld_y0       <= '0;
            ld_x1       <= '0;
            ld_y1       <= '0;
            cnt         <= '0;
            drop_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            ld_start <= issue;
            cnt      <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (pop) begin
                anc       <= head;
                anc_valid <= 1'b1;
            end
            if (issue) begin
                ld_x0 <= dot ? head.x : anc.x;
                ld_y0 <= dot ? head.y : anc.y;
                ld_x1 <= head.x;
                ld_y1 <= head.y;
            end
            if (expire)
                timeout_err <= 1'b1;
            if (pt_valid && full && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stroke_sequencer.sv
// Bench for stroke_sequencer: queue-based reference model checked every
// cycle, plus directed scenarios with literal segment expectations.
module tb_stroke_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pt_valid = 1'b0;
    logic       pt_pen = 1'b0;
    logic [9:0] pt_x = '0;
    logic [8:0] pt_y = '0;
    logic       ld_done = 1'b0;
    logic       pt_ready;
    logic       ld_start;
    logic [9:0] ld_x0;
    logic [8:0] ld_y0;
    logic [9:0] ld_x1;
    logic [8:0] ld_y1;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit pen;
        int x;
        int y;
    } mpt_t;

    mpt_t mq[$];
    mpt_t m_anc;
    mpt_t mp;
    bit   m_anc_ok, m_wait, m_start, m_terr, m_link, m_full;
    int   m_age, m_drop, m_x0, m_y0, m_x1, m_y1;

    logic [37:0] seg_log[$];
    bit done_en  = 1'b1;
    bit rand_dly = 1'b0;
    int done_dly = 5;
    int t5_n, t5_m;

    stroke_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pt_valid    (pt_valid),
        .pt_pen      (pt_pen),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_ready    (pt_ready),
        .ld_start    (ld_start),
        .ld_x0       (ld_x0),
        .ld_y0       (ld_y0),
        .ld_x1       (ld_x1),
        .ld_y1       (ld_y1),
        .ld_done     (ld_done),
        .busy        (busy),
        .drop_cnt    (drop_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] seg(int x0, int y0, int x1, int y1);
        return {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
    endfunction

    function automatic logic [37:0] seg_at(int i);
        return (seg_log.size() > i) ? seg_log[i] : '1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_anc_ok = 0; m_wait = 0; m_start = 0; m_terr = 0;
        m_age = 0; m_drop = 0;
        m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
    endtask

    // Reference model: advance one clock using the rules for points,
    // anchors, segments, timeouts and drops.
    always @(posedge clk) begin
        if (!reset) begin
            m_full  = (mq.size() == DEPTH);
            m_start = 0;
            if (m_wait) begin
                if (ld_done) begin
                    m_wait = 0;
                end else if (m_age == TIMEOUT - 1) begin
                    m_terr = 1;
                    m_wait = 0;
                end else begin
                    m_age++;
                end
            end else if (mq.size() > 0) begin
                mp = mq.pop_front();
                m_link = m_anc_ok && m_anc.pen;
                if (mp.pen && !(m_link && mp.x == m_anc.x && mp.y == m_anc.y)) begin
                    m_start = 1;
                    m_wait  = 1;
                    m_age   = 0;
                    m_x0 = m_link ? m_anc.x : mp.x;
                    m_y0 = m_link ? m_anc.y : mp.y;
                    m_x1 = mp.x;
                    m_y1 = mp.y;
                end
                m_anc = mp;
                m_anc_ok = 1;
            end
            if (pt_valid) begin
                if (m_full) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq.push_back('{pt_pen, int'(pt_x), int'(pt_y)});
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of issued segments.
    always @(negedge clk) begin
        if (!reset) begin
            check("pt_ready", 64'(pt_ready), 64'(mq.size() < DEPTH));
            check("busy", 64'(busy), 64'(m_wait || mq.size() > 0));
            check("ld_start", 64'(ld_start), 64'(m_start));
            check("ld_x0", 64'(ld_x0), 64'(m_x0));
            check("ld_y0", 64'(ld_y0), 64'(m_y0));
            check("ld_x1", 64'(ld_x1), 64'(m_x1));
            check("ld_y1", 64'(ld_y1), 64'(m_y1));
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            check("timeout_err", 64'(timeout_err), 64'(m_terr));
            if (ld_start)
                seg_log.push_back({ld_x0, ld_y0, ld_x1, ld_y1});
        end
    end

    // Line drawer stand-in: pulses ld_done a set number of cycles after start.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (ld_start && done_en && !reset) begin
                d = rand_dly ? int'($urandom_range(1, 20)) : done_dly;
                repeat (d - 1) @(negedge clk);
                ld_done = 1'b1;
                @(negedge clk);
                ld_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push1(bit pen, int x, int y);
        @(negedge clk);
        pt_valid = 1'b1;
        pt_pen   = pen;
        pt_x     = 10'(x);
        pt_y     = 9'(y);
    endtask

    task automatic release_in();
        @(negedge clk);
        pt_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        seg_log.delete();
    endtask

    task automatic wait_idle(string name, int bound);
        int n = 0;
        while ((busy || ld_start) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < bound), 64'd1);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_ld_start", 64'(ld_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pt_ready", 64'(pt_ready), 64'd1);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_ld_xy", 64'({ld_x0, ld_y0, ld_x1, ld_y1}), 64'd0);
        #20;
        reset = 1'b0;

        // T1: single dot, one-cycle latency from accept to start
        push1(1, 10, 20);
        release_in();
        check("t1_no_start_yet", 64'(ld_start), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_start", 64'(ld_start), 64'd1);
        check("t1_endpoints", 64'({ld_x0, ld_y0, ld_x1, ld_y1}),
              64'(seg(10, 20, 10, 20)));
        @(negedge clk);
        check("t1_start_pulse", 64'(ld_start), 64'd0);
        wait_idle("t1_idle", 100);
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_nseg", 64'(seg_log.size()), 64'd1);

        // T2: dot then connecting segment
        do_reset();
        push1(1, 10, 20);
        push1(1, 30, 25);
        release_in();
        wait_idle("t2_idle", 200);
        check("t2_nseg", 64'(seg_log.size()), 64'd2);
        check("t2_seg0", 64'(seg_at(0)), 64'(seg(10, 20, 10, 20)));
        check("t2_seg1", 64'(seg_at(1)), 64'(seg(10, 20, 30, 25)));

        // T3: pen-up breaks the stroke
        do_reset();
        push1(1, 10, 20);
        push1(0, 50, 50);
        push1(1, 60, 60);
        release_in();
        wait_idle("t3_idle", 200);
        check("t3_nseg", 64'(seg_log.size()), 64'd2);
        check("t3_seg0", 64'(seg_at(0)), 64'(seg(10, 20, 10, 20)));
        check("t3_seg1", 64'(seg_at(1)), 64'(seg(60, 60, 60, 60)));

        // T4: duplicate point skipped
        do_reset();
        push1(1, 5, 5);
        push1(1, 5, 5);
        push1(1, 6, 5);
        release_in();
        wait_idle("t4_idle", 200);
        check("t4_nseg", 64'(seg_log.size()), 64'd2);
        check("t4_seg0", 64'(seg_at(0)), 64'(seg(5, 5, 5, 5)));
        check("t4_seg1", 64'(seg_at(1)), 64'(seg(5, 5, 6, 5)));

        // T5: no done, burst of 12 fills the FIFO, drops and times out
        do_reset();
        done_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    push1(1, i, i);
                release_in();
                check("t5_pt_ready", 64'(pt_ready), 64'd0);
                check("t5_drop_cnt", 64'(drop_cnt), 64'd3);
            end
            begin
                t5_n = 0;
                while (!ld_start && t5_n < 50) begin
                    @(negedge clk);
                    t5_n++;
                end
                t5_m = 0;
                while (!timeout_err && t5_m < 100) begin
                    @(negedge clk);
                    t5_m++;
                end
                check("t5_timeout_latency", 64'(t5_m), 64'd16);
            end
        join
        done_en = 1'b1;
        wait_idle("t5_idle", 600);
        check("t5_timeout_err", 64'(timeout_err), 64'd1);
        check("t5_nseg", 64'(seg_log.size()), 64'd9);
        check("t5_seg0", 64'(seg_at(0)), 64'(seg(0, 0, 0, 0)));
        check("t5_seg8", 64'(seg_at(8)), 64'(seg(7, 7, 8, 8)));

        // T6: async reset in the middle of a wait with points queued
        do_reset();
        done_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push1(1, 100 + i, 50);
        release_in();
        repeat (2) @(negedge clk);
        check("t6_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_ld_start", 64'(ld_start), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_pt_ready", 64'(pt_ready), 64'd1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        seg_log.delete();
        done_en = 1'b1;
        push1(1, 7, 7);
        release_in();
        wait_idle("t6_idle", 200);
        check("t6_nseg", 64'(seg_log.size()), 64'd1);
        check("t6_seg0", 64'(seg_at(0)), 64'(seg(7, 7, 7, 7)));

        // T7: drop counter saturates
        do_reset();
        done_en = 1'b0;
        for (int i = 0; i < 320; i++)
            push1(1, i % 600, i % 400);
        release_in();
        check("t7_drop_sat", 64'(drop_cnt), 64'd255);
        done_en = 1'b1;
        wait_idle("t7_idle", 1000);

        // Random traffic with random drawer latency, some beyond the timeout
        do_reset();
        rand_dly = 1'b1;
        for (int i = 0; i < 800; i++) begin
            int rx, ry;
            rx = int'($urandom_range(0, 7));
            ry = int'($urandom_range(0, 7));
            @(negedge clk);
            pt_valid = 1'($urandom_range(0, 1));
            pt_pen   = ($urandom_range(0, 3) != 0);
            pt_x     = (rx == 7) ? 10'd639 : 10'(rx % 3);
            pt_y     = (ry == 7) ? 9'd479 : 9'(ry % 3);
        end
        release_in();
        wait_idle("rand_idle", 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
